// File: rtl/gate_net_pkg.sv
// Shared constants, state type and thermometer helper for the
// gate-network input encoder.
package gate_net_pkg;

  localparam int N_FEAT        = 49;
  localparam int BITS_PER_FEAT = 2;
  localparam int FEAT_W        = 8;
  localparam int FRAME_W       = N_FEAT * BITS_PER_FEAT;
  localparam int PROD_W        = FEAT_W + $clog2(BITS_PER_FEAT + 1);
  localparam int IDX_W         = $clog2(N_FEAT);

  typedef enum logic {
    FILL,
    HOLD_FULL
  } enc_state_e;

  // Bit k set when value*(B+1) >= (k+1)*2^FEAT_W, full-width compare.
  function automatic logic [BITS_PER_FEAT-1:0] therm_encode(
    input logic [FEAT_W-1:0] value
  );
    logic [PROD_W:0] prod;
    logic [PROD_W:0] thr;
    therm_encode = '0;
    prod = (PROD_W+1)'(value) * (PROD_W+1)'(BITS_PER_FEAT + 1);
    for (int k = 0; k < BITS_PER_FEAT; k++) begin
      thr = (PROD_W+1)'(k + 1) << FEAT_W;
      therm_encode[k] = (prod >= thr);
    end
  endfunction

endpackage

// File: rtl/gate_net_input_encoder_therm_slice.sv
// Combinational thermometer slice: one feature sample to
// BITS_PER_FEAT monotone bits.
module gate_net_therm_slice
  import gate_net_pkg::*;
(
  input  logic [FEAT_W-1:0]        feat_i,
  output logic [BITS_PER_FEAT-1:0] bits_o
);

  assign bits_o = therm_encode(feat_i);

endmodule

// File: rtl/gate_net_input_encoder.sv
// Streaming feature encoder: assembles thermometer-coded features
// into a frame, double buffered toward the classifier.
module gate_net_input_encoder
  import gate_net_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [FEAT_W-1:0]  s_feat,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FRAME_W-1:0] m_bits,
  output logic               frame_err,
  output logic [15:0]        frame_cnt
);

  enc_state_e               state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [FRAME_W-1:0]       asm_q, asm_d;
  logic [FRAME_W-1:0]       out_q, out_d;
  logic                     vld_q, vld_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     err_q, err_d;

  logic [BITS_PER_FEAT-1:0] enc;
  logic [FRAME_W-1:0]       asm_wr;
  logic                     at_end;
  logic                     out_free;

  gate_net_therm_slice u_slice (
    .feat_i (s_feat),
    .bits_o (enc)
  );

  assign at_end   = (idx_q == IDX_W'(N_FEAT - 1));
  assign out_free = !vld_q || m_ready;

  always_comb begin
    asm_wr = asm_q;
    for (int i = 0; i < N_FEAT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        asm_wr[i*BITS_PER_FEAT +: BITS_PER_FEAT] = enc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    out_d   = out_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (vld_q && m_ready) begin
      vld_d = 1'b0;
    end
    unique case (state_q)
      FILL: begin
        if (s_valid) begin
          unique case (1'b1)
            s_last && at_end: begin
              idx_d = '0;
              if (out_free) begin
                out_d = asm_wr;
                vld_d = 1'b1;
                cnt_d = cnt_q + 16'd1;
                asm_d = '0;
              end else begin
                asm_d   = asm_wr;
                state_d = HOLD_FULL;
              end
            end
            s_last && !at_end,
            !s_last && at_end: begin
              // Resync: drop the partial frame, restart at feature 0.
              idx_d = '0;
              asm_d = '0;
              err_d = 1'b1;
            end
            !s_last && !at_end: begin
              asm_d = asm_wr;
              idx_d = idx_q + IDX_W'(1);
            end
            default: ;
          endcase
        end
      end
      HOLD_FULL: begin
        if (out_free) begin
          out_d   = asm_q;
          vld_d   = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          asm_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      asm_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign s_ready   = (state_q == FILL);
  assign m_valid   = vld_q;
  assign m_bits    = out_q;
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_gate_net_input_encoder.sv
// Scoreboard bench for the gate-network input encoder.
// Expected frames are queued at send time and popped on handshake.
module tb_gate_net_input_encoder;

  localparam int NF = 49;
  localparam int FW = 98;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_feat;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [FW-1:0] m_bits;
  logic          frame_err;
  logic [15:0]   frame_cnt;

  int chk;
  int errs;
  int err_seen;
  int model_cnt;
  logic [15:0] cnt_prev;

  logic [FW-1:0] exp_bits_q[$];
  logic [15:0]   exp_cnt_q[$];
  logic [7:0]    feat_a[NF];

  gate_net_input_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_feat    (s_feat),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_bits    (m_bits),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc_ref(input logic [7:0] v);
    int p;
    p = int'(v) * 3;
    enc_ref[0] = (p >= 256);
    enc_ref[1] = (p >= 512);
  endfunction

  function automatic logic [FW-1:0] frame_ref();
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < NF; i++) begin
      r[2*i +: 2] = enc_ref(feat_a[i]);
    end
    return r;
  endfunction

  // Output-side scoreboard and error-pulse monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) begin
        err_seen++;
        chk++;
        if (frame_cnt !== cnt_prev) begin
          errs++;
          $display("FAIL err_vs_cnt cnt=%0d prev=%0d",
                   frame_cnt, cnt_prev);
        end
      end
      if (m_valid && m_ready) begin
        chk++;
        if (exp_bits_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_frame got=%h", m_bits);
        end else begin
          logic [FW-1:0] eb;
          logic [15:0]   ec;
          eb = exp_bits_q.pop_front();
          ec = exp_cnt_q.pop_front();
          if (m_bits !== eb) begin
            errs++;
            $display("FAIL frame_bits got=%h exp=%h", m_bits, eb);
          end
          chk++;
          if (frame_cnt !== ec) begin
            errs++;
            $display("FAIL frame_cnt got=%0d exp=%0d",
                     frame_cnt, ec);
          end
        end
      end
    end
    cnt_prev = frame_cnt;
  end

  task automatic apply_reset();
    s_valid = 1'b0;
    s_feat  = '0;
    s_last  = 1'b0;
    rst_n   = 1'b0;
    #12;
    exp_bits_q.delete();
    exp_cnt_q.delete();
    model_cnt = 0;
    err_seen  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] f, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_feat  = f;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      errs++;
      $display("FAIL beat_timeout s_ready=%b exp=1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_exp();
    model_cnt++;
    exp_bits_q.push_back(frame_ref());
    exp_cnt_q.push_back(16'(model_cnt));
  endtask

  // Sends n beats, s_last on beat index last_at (-1 for none).
  task automatic send_frame(input int n, input int last_at,
                            input bit good);
    if (good) push_exp();
    for (int i = 0; i < n; i++) begin
      send_beat(feat_a[i], (i == last_at));
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_bits_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk++;
    if (exp_bits_q.size() != 0) begin
      errs++;
      $display("FAIL %s_drain pending=%0d exp=0",
               name, exp_bits_q.size());
    end
  endtask

  task automatic test_reset();
    m_ready = 1'b1;
    apply_reset();
    chk++;
    if ({s_ready, m_valid, frame_err} !== 3'b100) begin
      errs++;
      $display("FAIL reset_flags got=%b exp=100",
               {s_ready, m_valid, frame_err});
    end
    chk++;
    if (m_bits !== '0 || frame_cnt !== 16'd0) begin
      errs++;
      $display("FAIL reset_data bits=%h cnt=%0d exp=0",
               m_bits, frame_cnt);
    end
  endtask

  task automatic test_thresholds();
    apply_reset();
    m_ready = 1'b1;
    for (int i = 0; i < NF; i++) feat_a[i] = 8'((i * 37) % 256);
    push_exp();
    for (int i = 0; i < NF - 1; i++) send_beat(feat_a[i], 1'b0);
    chk++;
    if (m_valid !== 1'b0) begin
      errs++;
      $display("FAIL thr_early_valid got=%b exp=0", m_valid);
    end
    send_beat(feat_a[NF-1], 1'b1);
    chk++;
    if (m_valid !== 1'b1) begin
      errs++;
      $display("FAIL thr_latency m_valid=%b exp=1", m_valid);
    end
    chk++;
    if (m_bits[5:0] !== 6'b00_00_00) begin
      errs++;
      $display("FAIL thr_low_pairs got=%b exp=000000",
               m_bits[5:0]);
    end
    drain("thr");
    chk++;
    if (frame_cnt !== 16'd1) begin
      errs++;
      $display("FAIL thr_cnt got=%0d exp=1", frame_cnt);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] bv [5];
    apply_reset();
    m_ready = 1'b1;
    bv = '{8'd85, 8'd86, 8'd170, 8'd171, 8'd255};
    for (int i = 0; i < NF; i++) feat_a[i] = (i < 5) ? bv[i] : 8'd0;
    send_frame(NF, NF - 1, 1'b1);
    chk++;
    if (m_bits[9:0] !== 10'b11_11_01_01_00) begin
      errs++;
      $display("FAIL boundary got=%b exp=1111010100", m_bits[9:0]);
    end
    drain("bnd");
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] fa, fb;
    apply_reset();
    m_ready = 1'b0;
    for (int i = 0; i < NF; i++) feat_a[i] = 8'($urandom_range(255));
    fa = frame_ref();
    send_frame(NF, NF - 1, 1'b1);
    for (int i = 0; i < NF; i++) feat_a[i] = 8'($urandom_range(255));
    fb = frame_ref();
    send_frame(NF, NF - 1, 1'b1);
    chk++;
    if ({s_ready, m_valid} !== 2'b01 || m_bits !== fa) begin
      errs++;
      $display("FAIL bp_hold rdy=%b vld=%b bits=%h exp=%h",
               s_ready, m_valid, m_bits, fa);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk++;
    if ({s_ready, m_valid} !== 2'b11 || m_bits !== fb) begin
      errs++;
      $display("FAIL bp_next rdy=%b vld=%b bits=%h exp=%h",
               s_ready, m_valid, m_bits, fb);
    end
    chk++;
    if (frame_cnt !== 16'd2) begin
      errs++;
      $display("FAIL bp_cnt got=%0d exp=2", frame_cnt);
    end
    m_ready = 1'b1;
    drain("bp");
  endtask

  task automatic test_early_last();
    apply_reset();
    m_ready = 1'b1;
    for (int i = 0; i < NF; i++) feat_a[i] = 8'(255 - i * 5);
    send_frame(10, 9, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk++;
    if (err_seen !== 1 || m_valid !== 1'b0) begin
      errs++;
      $display("FAIL early_last errs=%0d vld=%b exp=1,0",
               err_seen, m_valid);
    end
    send_frame(NF, NF - 1, 1'b1);
    drain("early");
  endtask

  task automatic test_missing_last();
    apply_reset();
    m_ready = 1'b1;
    for (int i = 0; i < NF; i++) feat_a[i] = 8'(i * 5 + 3);
    send_frame(NF, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk++;
    if (err_seen !== 1 || frame_cnt !== 16'd0) begin
      errs++;
      $display("FAIL missing_last errs=%0d cnt=%0d exp=1,0",
               err_seen, frame_cnt);
    end
    send_frame(NF, NF - 1, 1'b1);
    drain("miss");
  endtask

  task automatic test_async_reset();
    apply_reset();
    m_ready = 1'b0;
    for (int i = 0; i < NF; i++) feat_a[i] = 8'(i * 3);
    send_frame(NF, NF - 1, 1'b1);
    for (int i = 0; i < 29; i++) send_beat(feat_a[i], 1'b0);
    s_valid = 1'b1;
    s_feat  = feat_a[29];
    #2;
    rst_n = 1'b0;
    #1;
    chk++;
    if ({m_valid, s_ready} !== 2'b01 || frame_cnt !== 16'd0) begin
      errs++;
      $display("FAIL async_rst vld=%b rdy=%b cnt=%0d exp=0,1,0",
               m_valid, s_ready, frame_cnt);
    end
    m_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < NF; i++) feat_a[i] = 8'(200 - i);
    send_frame(NF, NF - 1, 1'b1);
    drain("arst");
  endtask

  initial begin
    chk       = 0;
    errs      = 0;
    err_seen  = 0;
    model_cnt = 0;
    cnt_prev  = '0;
    m_ready   = 1'b1;
    s_valid   = 1'b0;
    s_feat    = '0;
    s_last    = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_thresholds();
    test_boundary();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
